// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb game sequencer.
package bomb_pkg;

  localparam int TIME_W   = 12;
  localparam int STRIKE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_RUN      = 3'd3,
    ST_DEFUSED  = 3'd4,
    ST_EXPLODED = 3'd5
  } state_t;

  function automatic logic [STRIKE_W-1:0] strike_inc(input logic [STRIKE_W-1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/bomb_sequencer_sec_prescaler.sv
// Game-second prescaler: counts 0..period-1 while enabled, flags the last count.
// A clear restarts from 0 and picks up the new period at once.
module sec_prescaler #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                wrap
);

  logic [PERIOD_W-1:0] count_r;
  logic [PERIOD_W-1:0] period_r;
  logic                at_end_s;

  assign at_end_s = (count_r == (period_r - PERIOD_W'(1)));
  assign wrap     = enable && !clear && at_end_s;

  // Counter and latched period; the period only changes on clear or wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= {PERIOD_W{1'b0}};
      period_r <= {PERIOD_W{1'b0}};
    end else if (clear) begin
      count_r  <= {PERIOD_W{1'b0}};
      period_r <= period;
    end else if (enable) begin
      if (at_end_s) begin
        count_r  <= {PERIOD_W{1'b0}};
        period_r <= period;
      end else begin
        count_r  <= count_r + PERIOD_W'(1);
      end
    end else begin
      count_r  <= count_r;
      period_r <= period_r;
    end
  end

endmodule

// File: rtl/bomb_sequencer.sv
// Bomb game sequencer: drives the countdown, counts strikes, reports the game result.
// Outputs are registered from the next-state decision, so they describe the state being entered.
module bomb_sequencer
  import bomb_pkg::*;
#(
  parameter int                TICKS_PER_SEC = 50_000_000,
  parameter int                MAX_STRIKES   = 3,
  parameter logic [TIME_W-1:0] INIT_TIME     = 12'h190
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                code_valid,
  input  logic                code_match,
  input  logic                cd_zero,
  output logic [TIME_W-1:0]   cd_init_time,
  output logic                cd_load,
  output logic                cd_switch_op,
  output logic                cd_sec_tick,
  output logic [STRIKE_W-1:0] strikes,
  output logic                armed,
  output logic                defused,
  output logic                exploded
);

  localparam int PERIOD_W = $clog2(TICKS_PER_SEC + 1);

  state_t                state_r, state_next_s;
  logic [STRIKE_W-1:0]   strikes_r, strikes_next_s;
  logic                  presc_clear_s;
  logic                  presc_wrap_s;
  logic [PERIOD_W-1:0]   period_s;
  logic                  cd_load_r, cd_switch_op_r, cd_sec_tick_r;
  logic                  armed_r, defused_r, exploded_r;

  // Each strike doubles the tick rate.
  assign period_s = PERIOD_W'(TICKS_PER_SEC >> strikes_next_s);

  sec_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state_r == ST_RUN),
    .clear  (presc_clear_s),
    .period (period_s),
    .wrap   (presc_wrap_s)
  );

  // Next-state, strike and prescaler-clear decisions; cd_zero outranks any code entry.
  always_comb begin
    state_next_s   = state_r;
    strikes_next_s = strikes_r;
    presc_clear_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        strikes_next_s = {STRIKE_W{1'b0}};
        if (start_btn) state_next_s = ST_LOAD;
        else           state_next_s = ST_IDLE;
      end
      ST_LOAD:  state_next_s = ST_START;
      ST_START: begin
        state_next_s  = ST_RUN;
        presc_clear_s = 1'b1;
      end
      ST_RUN: begin
        if (cd_zero) begin
          state_next_s = ST_EXPLODED;
        end else if (code_valid && code_match) begin
          state_next_s = ST_DEFUSED;
        end else if (code_valid) begin
          strikes_next_s = strike_inc(strikes_r);
          presc_clear_s  = 1'b1;
          if (strikes_next_s == STRIKE_W'(MAX_STRIKES)) state_next_s = ST_EXPLODED;
          else                                          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DEFUSED, ST_EXPLODED: begin
        if (start_btn) begin
          state_next_s   = ST_IDLE;
          strikes_next_s = {STRIKE_W{1'b0}};
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        strikes_next_s = {STRIKE_W{1'b0}};
      end
    endcase
  end

  // State, strike counter and output registers; a tick is dropped whenever RUN is being left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      strikes_r      <= {STRIKE_W{1'b0}};
      cd_load_r      <= 1'b0;
      cd_switch_op_r <= 1'b0;
      cd_sec_tick_r  <= 1'b0;
      armed_r        <= 1'b0;
      defused_r      <= 1'b0;
      exploded_r     <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      strikes_r      <= strikes_next_s;
      cd_load_r      <= (state_next_s == ST_LOAD);
      cd_switch_op_r <= (state_next_s == ST_START) ||
                        ((state_r == ST_RUN) && (state_next_s == ST_DEFUSED));
      cd_sec_tick_r  <= (state_r == ST_RUN) && (state_next_s == ST_RUN) && presc_wrap_s;
      armed_r        <= (state_next_s == ST_RUN);
      defused_r      <= (state_next_s == ST_DEFUSED);
      exploded_r     <= (state_next_s == ST_EXPLODED);
    end
  end

  assign cd_init_time = INIT_TIME;
  assign cd_load      = cd_load_r;
  assign cd_switch_op = cd_switch_op_r;
  assign cd_sec_tick  = cd_sec_tick_r;
  assign strikes      = strikes_r;
  assign armed        = armed_r;
  assign defused      = defused_r;
  assign exploded     = exploded_r;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Self-checking bench for bomb_sequencer: directed game scenarios, then random play
// checked every cycle against an event-level model of the game rules.
module tb_bomb_sequencer;

  localparam int TPS  = 4;
  localparam int MAXS = 3;

  localparam int G_IDLE = 0, G_LOAD = 1, G_START = 2, G_RUN = 3, G_DEF = 4, G_EXPL = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0, code_valid = 1'b0, code_match = 1'b0, cd_zero = 1'b0;
  logic [11:0] cd_init_time;
  logic        cd_load, cd_switch_op, cd_sec_tick, armed, defused, exploded;
  logic [1:0]  strikes;

  int n_checks = 0;
  int n_fail   = 0;

  int m_stage, m_strikes, m_since, m_period;
  logic       exp_load, exp_sw, exp_tick, exp_armed, exp_def, exp_expl;
  logic [1:0] exp_strikes;
  logic [7:0] act_v, exp_v;

  bomb_sequencer #(.TICKS_PER_SEC(TPS), .MAX_STRIKES(MAXS), .INIT_TIME(12'h190)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .code_valid   (code_valid),
    .code_match   (code_match),
    .cd_zero      (cd_zero),
    .cd_init_time (cd_init_time),
    .cd_load      (cd_load),
    .cd_switch_op (cd_switch_op),
    .cd_sec_tick  (cd_sec_tick),
    .strikes      (strikes),
    .armed        (armed),
    .defused      (defused),
    .exploded     (exploded)
  );

  always #5 clk = ~clk;

  task automatic set_indicators();
    exp_armed   = (m_stage == G_RUN);
    exp_def     = (m_stage == G_DEF);
    exp_expl    = (m_stage == G_EXPL);
    exp_strikes = 2'(m_strikes);
  endtask

  task automatic model_reset();
    m_stage = G_IDLE; m_strikes = 0; m_since = 0; m_period = TPS;
    exp_load = 1'b0; exp_sw = 1'b0; exp_tick = 1'b0;
    set_indicators();
  endtask

  // Game rules applied to the inputs seen at one rising edge; ticks fall every
  // m_period edges after the last (re)start of the second timer.
  task automatic model_step(input logic sb, input logic cv, input logic cm, input logic cz);
    exp_load = 1'b0; exp_sw = 1'b0; exp_tick = 1'b0;
    case (m_stage)
      G_IDLE:  if (sb) begin m_stage = G_LOAD; exp_load = 1'b1; end
      G_LOAD:  begin m_stage = G_START; exp_sw = 1'b1; end
      G_START: begin m_stage = G_RUN; m_since = 0; m_period = TPS; end
      G_RUN: begin
        if (cz) m_stage = G_EXPL;
        else if (cv && cm) begin m_stage = G_DEF; exp_sw = 1'b1; end
        else if (cv) begin
          m_strikes = m_strikes + 1;
          m_since   = 0;
          m_period  = TPS >> m_strikes;
          if (m_strikes == MAXS) m_stage = G_EXPL;
        end else begin
          m_since = m_since + 1;
          if (m_since % m_period == 0) exp_tick = 1'b1;
        end
      end
      default: if (sb) begin m_stage = G_IDLE; m_strikes = 0; end
    endcase
    set_indicators();
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sb, input logic cv, input logic cm, input logic cz);
    start_btn = sb; code_valid = cv; code_match = cm; cd_zero = cz;
    @(posedge clk);
    #1;
    model_step(sb, cv, cm, cz);
    start_btn = 1'b0; code_valid = 1'b0; code_match = 1'b0; cd_zero = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    start_btn = 1'b0; code_valid = 1'b0; code_match = 1'b0; cd_zero = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    lit("reset_outputs_clear", int'({cd_load, cd_switch_op, cd_sec_tick, armed, defused, exploded}), 0);
    lit("reset_strikes_clear", int'(strikes), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      act_v = {cd_load, cd_switch_op, cd_sec_tick, armed, defused, exploded, strikes};
      exp_v = {exp_load, exp_sw, exp_tick, exp_armed, exp_def, exp_expl, exp_strikes};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got load/sw/tick/arm/def/expl/strk=%b expected %b",
                 $time, act_v, exp_v);
      end
      n_checks++;
      if (cd_init_time !== 12'h190) begin
        n_fail++;
        $display("FAIL init_time t=%0t got %h expected 190", $time, cd_init_time);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lit("reset_state", int'({cd_load, cd_switch_op, cd_sec_tick, armed, defused, exploded, strikes}), 0);

    // Start sequence and nominal tick rate
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("load_pulse", cd_load, 1);
    lit("model_load", exp_load, 1);
    idle(1);
    lit("switch_on_start", cd_switch_op, 1);
    lit("load_one_cycle", cd_load, 0);
    idle(1);
    lit("armed", armed, 1);
    idle(3);
    lit("no_early_tick", cd_sec_tick, 0);
    idle(1);
    lit("tick_period4", cd_sec_tick, 1);
    lit("model_tick4", exp_tick, 1);

    // Strikes speed up the ticks, third one explodes
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit("strike1", strikes, 1);
    idle(1);
    lit("no_tick_half", cd_sec_tick, 0);
    idle(1);
    lit("tick_period2", cd_sec_tick, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit("strike2", strikes, 2);
    idle(1);
    lit("tick_period1_a", cd_sec_tick, 1);
    idle(1);
    lit("tick_period1_b", cd_sec_tick, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit("exploded_third", exploded, 1);
    lit("strikes_max", strikes, 3);
    lit("disarmed_on_explode", armed, 0);
    idle(1);
    lit("no_tick_exploded", cd_sec_tick, 0);

    // Back to idle, then a defuse
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("idle_after_explode", exploded, 0);
    lit("strikes_cleared", strikes, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("restart_load", cd_load, 1);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    lit("defused", defused, 1);
    lit("defuse_switch", cd_switch_op, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit("code_ignored_defused", strikes, 0);
    lit("defuse_switch_once", cd_switch_op, 0);

    // cd_zero outranks a correct code
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    lit("zero_beats_code", exploded, 1);
    lit("zero_no_switch", cd_switch_op, 0);
    lit("zero_not_defused", defused, 0);

    // Asynchronous reset in the middle of a run
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    async_reset();
    idle(6);
    lit("idle_after_reset", armed, 0);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      else step(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 149) == 0));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
